// File: rtl/block_fixed_loader.sv
// Serial-to-block pixel loader: gathers NUM_INTEGERS samples, converts the block to
// fixed point and offers it downstream. Define BLOCK_FIXED_LEVEL_SHIFT_EN for JPEG level shift.

module multi_integer_to_fixed #(
   parameter int INT_BITS     = 16,
   parameter int FRAC_BITS    = 16,
   parameter int IN_BITS      = 8,
   parameter int NUM_INTEGERS = 64,
   parameter bit SIGNED_IN    = 1'b0
) (
   input  logic [NUM_INTEGERS*IN_BITS-1:0]               in_ints,
   output logic [NUM_INTEGERS*(INT_BITS+FRAC_BITS)-1:0]  out_fixed
);
   localparam int W = INT_BITS + FRAC_BITS;

   // Each element is extended to INT_BITS and placed above an all-zero fraction.
   for (genvar i = 0; i < NUM_INTEGERS; i++) begin : g_elem
      logic [IN_BITS-1:0] s;
      logic               ext;
      assign s   = in_ints[i*IN_BITS +: IN_BITS];
      assign ext = SIGNED_IN & s[IN_BITS-1];
      assign out_fixed[i*W +: W] = {{(INT_BITS-IN_BITS){ext}}, s, {FRAC_BITS{1'b0}}};
   end
endmodule

module block_fixed_loader #(
   parameter int INT_BITS     = 16,
   parameter int FRAC_BITS    = 16,
   parameter int INPUT_BITS   = 8,
   parameter int NUM_INTEGERS = 64,
   parameter int CNT_BITS     = 16
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [INPUT_BITS-1:0]                         in_data,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   output logic [NUM_INTEGERS*(INT_BITS+FRAC_BITS)-1:0]  out_fixed,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [$clog2(NUM_INTEGERS)-1:0]               sample_idx,
   output logic [CNT_BITS-1:0]                           blk_cnt
);
   localparam int W        = INT_BITS + FRAC_BITS;
   localparam int IDX_BITS = $clog2(NUM_INTEGERS);
   localparam int BUF_BITS = NUM_INTEGERS * INPUT_BITS;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_INTEGERS - 1);

   typedef enum logic [1:0] {
      ST_FILL    = 2'b00,
      ST_CONVERT = 2'b01,
      ST_HOLD    = 2'b10
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_BITS-1:0]     idx_q, idx_d;
   logic [BUF_BITS-1:0]     buf_q, buf_d;
   logic [NUM_INTEGERS*W-1:0] fixed_q, fixed_d;
   logic                    valid_q, valid_d;
   logic                    ready_q, ready_d;
   logic [CNT_BITS-1:0]     cnt_q, cnt_d;
   logic [BUF_BITS-1:0]     conv_in;
   logic [NUM_INTEGERS*W-1:0] conv_out;

`ifdef BLOCK_FIXED_LEVEL_SHIFT_EN
   localparam bit CONV_SIGNED = 1'b1;
   localparam logic [INPUT_BITS-1:0] BIAS = {1'b1, {(INPUT_BITS-1){1'b0}}};

   // Modulo subtraction of the mid-scale bias yields the two's complement level-shifted sample.
   for (genvar i = 0; i < NUM_INTEGERS; i++) begin : g_shift
      assign conv_in[i*INPUT_BITS +: INPUT_BITS] = buf_q[i*INPUT_BITS +: INPUT_BITS] - BIAS;
   end
`else
   localparam bit CONV_SIGNED = 1'b0;
   assign conv_in = buf_q;
`endif

   multi_integer_to_fixed #(
      .INT_BITS     (INT_BITS),
      .FRAC_BITS    (FRAC_BITS),
      .IN_BITS      (INPUT_BITS),
      .NUM_INTEGERS (NUM_INTEGERS),
      .SIGNED_IN    (CONV_SIGNED)
   ) u_conv (
      .in_ints   (conv_in),
      .out_fixed (conv_out)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      fixed_d = fixed_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_FILL: begin
            if (in_valid && ready_q) begin
               buf_d[idx_q*INPUT_BITS +: INPUT_BITS] = in_data;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_CONVERT;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_CONVERT: begin
            fixed_d = conv_out;
            valid_d = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_FILL;
            end
         end
         default: begin
            state_d = ST_FILL;
            idx_d   = '0;
            valid_d = 1'b0;
         end
      endcase
      // Registered so in_ready stays low through reset and rises on the first edge after release.
      ready_d = (state_d == ST_FILL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FILL;
         idx_q   <= '0;
         buf_q   <= '0;
         fixed_q <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         fixed_q <= fixed_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready   = ready_q;
   assign out_valid  = valid_q;
   assign out_fixed  = fixed_q;
   assign sample_idx = idx_q;
   assign blk_cnt    = cnt_q;
endmodule

// File: tb/tb_block_fixed_loader.sv
// Randomised and directed bench for block_fixed_loader against a queue-based reference model.
// Honours BLOCK_FIXED_LEVEL_SHIFT_EN to select the expected conversion.

module tb_block_fixed_loader;
   localparam int NI = 64;
   localparam int W  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NI*W-1:0]   out_fixed;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [5:0]        sample_idx;
   logic [15:0]       blk_cnt;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model: accepted samples, a pending-conversion flag and the presented block.
   int          mdlQ[$];
   bit          mdlConv;
   bit          mdlValid;
   bit          mdlReady;
   logic [31:0] mdlFixed[NI];
   logic [15:0] mdlCnt;

   block_fixed_loader #(
      .INT_BITS(16), .FRAC_BITS(16), .INPUT_BITS(8), .NUM_INTEGERS(NI), .CNT_BITS(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_fixed  (out_fixed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sample_idx (sample_idx),
      .blk_cnt    (blk_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] convSample(input int s);
`ifdef BLOCK_FIXED_LEVEL_SHIFT_EN
      return 32'((s - 128) * 65536);
`else
      return 32'(s * 65536);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkFixed();
      int bad = 0;
      for (int i = NI - 1; i >= 0; i--)
         if (out_fixed[i*W +: W] !== mdlFixed[i]) bad = i;
      checkOutput($sformatf("out_fixed[%0d]", bad), out_fixed[bad*W +: W], mdlFixed[bad]);
   endtask

   task automatic checkAll();
      checkOutput("in_ready", in_ready, mdlReady);
      checkOutput("out_valid", out_valid, mdlValid);
      checkOutput("sample_idx", sample_idx, mdlQ.size() % NI);
      checkOutput("blk_cnt", blk_cnt, mdlCnt);
      checkFixed();
   endtask

   task automatic modelEdge(input bit v, input int d, input bit r);
      if (mdlValid) begin
         if (r) begin
            mdlValid = 1'b0;
            mdlCnt++;
         end
      end else if (mdlConv) begin
         for (int i = 0; i < NI; i++) mdlFixed[i] = convSample(mdlQ[i]);
         mdlQ.delete();
         mdlConv  = 1'b0;
         mdlValid = 1'b1;
      end else if (v && mdlReady) begin
         mdlQ.push_back(d);
         if (mdlQ.size() == NI) mdlConv = 1'b1;
      end
      mdlReady = !mdlValid && !mdlConv;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
      checkAll();
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      modelEdge(v, int'(d), r);
      @(negedge clk);
   endtask

   task automatic applyReset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      mdlQ.delete();
      mdlConv  = 1'b0;
      mdlValid = 1'b0;
      mdlReady = 1'b0;
      mdlCnt   = '0;
      for (int i = 0; i < NI; i++) mdlFixed[i] = '0;
      #2;
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_sample_idx", sample_idx, 0);
      checkOutput("rst_blk_cnt", blk_cnt, 0);
      checkFixed();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      applyReset();
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("in_ready_after_reset", in_ready, 1'b1);

      // Ramp 0..63 back to back with downstream always ready.
      for (int i = 0; i < NI; i++) applyStimulus(1'b1, 8'(i), 1'b1);
      checkOutput("valid_not_yet", out_valid, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("valid_latency", out_valid, 1'b1);
`ifdef BLOCK_FIXED_LEVEL_SHIFT_EN
      checkOutput("ramp_elem63", out_fixed[63*W +: W], 32'hFFBF0000);
`else
      checkOutput("ramp_elem63", out_fixed[63*W +: W], 32'h003F0000);
      checkOutput("ramp_elem5", out_fixed[5*W +: W], 32'h00050000);
`endif
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("blk_cnt_first", blk_cnt, 16'd1);
      checkOutput("in_ready_after_handoff", in_ready, 1'b1);

      // Same ramp with downstream stalled for 10 cycles.
      for (int i = 0; i < NI; i++) applyStimulus(1'b1, 8'(i), 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("stall_in_ready", in_ready, 1'b0);
         applyStimulus(1'b1, 8'hAA, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("blk_cnt_stall", blk_cnt, 16'd2);

      // Valid toggling every cycle with all-0xFF samples.
      for (int k = 0; k < 200 && !mdlConv; k++) applyStimulus(k % 2 == 0, 8'hFF, 1'b1);
      checkOutput("toggle_complete", mdlConv, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
`ifdef BLOCK_FIXED_LEVEL_SHIFT_EN
      checkOutput("toggle_elem0", out_fixed[0 +: W], 32'h007F0000);
`else
      checkOutput("toggle_elem0", out_fixed[0 +: W], 32'h00FF0000);
`endif
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Reset with a partial block, then a fresh block of 0x05.
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
      applyReset();
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < NI; i++) applyStimulus(1'b1, 8'h05, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
`ifndef BLOCK_FIXED_LEVEL_SHIFT_EN
      checkOutput("fresh_elem40", out_fixed[40*W +: W], 32'h00050000);
`endif
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("blk_cnt_after_reset", blk_cnt, 16'd1);

`ifdef BLOCK_FIXED_LEVEL_SHIFT_EN
      // Level-shift corner samples 0, 128, 255, 1 repeated.
      for (int i = 0; i < NI; i++) begin
         logic [7:0] pat [4] = '{8'd0, 8'd128, 8'd255, 8'd1};
         applyStimulus(1'b1, pat[i%4], 1'b1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("ls_elem0", out_fixed[0*W +: W], 32'hFF800000);
      checkOutput("ls_elem1", out_fixed[1*W +: W], 32'h00000000);
      checkOutput("ls_elem2", out_fixed[2*W +: W], 32'h007F0000);
      checkOutput("ls_elem3", out_fixed[3*W +: W], 32'hFF810000);
      applyStimulus(1'b0, 8'h00, 1'b1);
`endif

      // Random traffic with one reset in the middle.
      for (int i = 0; i < 900; i++) begin
         if (i == 450) applyReset();
         applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
